hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/pipeline_pkg.sv | 19 +
 rtl/hazard_ctrl_if.sv | 44 ++++
 rtl/fwd_unit.sv | 23 ++
 rtl/hazard_ctrl.sv | 136 +++++++++++++
 tb/tb_hazard_ctrl.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline types: register-index width, zero register, forward selects, hazard FSM states.
package pipeline_pkg;

  localparam int unsigned REG_W     = 5;
  localparam int unsigned STALL_CW  = 2;
  localparam logic [REG_W-1:0] XZR  = 5'd31;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_WB  = 2'd1,
    FWD_MEM = 2'd2
  } fwd_sel_t;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } hz_state_t;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side bundle of the hazard controller: stage register fields in, enables/flushes/forwards out.
interface hazard_ctrl_if;
  import pipeline_pkg::*;

  logic [REG_W-1:0] id_Ra;
  logic [REG_W-1:0] id_Rb;
  logic             id_useRa;
  logic             id_useRb;
  logic             id_isBcond;
  logic [REG_W-1:0] ex_Rw;
  logic             ex_RegWrite;
  logic             ex_MemRead;
  logic             ex_setFlags;
  logic [REG_W-1:0] ex_Ra;
  logic [REG_W-1:0] ex_Rb;
  logic [REG_W-1:0] mem_Rw;
  logic             mem_RegWrite;
  logic             mem_setFlags;
  logic             br_taken;
  logic [REG_W-1:0] wb_Rw;
  logic             wb_RegWrite;

  logic             pc_en;
  logic             if_id_en;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             ex_mem_flush;
  fwd_sel_t         fwdA;
  fwd_sel_t         fwdB;

  modport master (
    output id_Ra, id_Rb, id_useRa, id_useRb, id_isBcond,
           ex_Rw, ex_RegWrite, ex_MemRead, ex_setFlags, ex_Ra, ex_Rb,
           mem_Rw, mem_RegWrite, mem_setFlags, br_taken, wb_Rw, wb_RegWrite,
    input  pc_en, if_id_en, if_id_flush, id_ex_flush, ex_mem_flush, fwdA, fwdB
  );

  modport slave (
    input  id_Ra, id_Rb, id_useRa, id_useRb, id_isBcond,
           ex_Rw, ex_RegWrite, ex_MemRead, ex_setFlags, ex_Ra, ex_Rb,
           mem_Rw, mem_RegWrite, mem_setFlags, br_taken, wb_Rw, wb_RegWrite,
    output pc_en, if_id_en, if_id_flush, id_ex_flush, ex_mem_flush, fwdA, fwdB
  );
endinterface

// File: rtl/fwd_unit.sv
// Operand forward select for one EX source: MEM result beats WB result; XZR never forwards.
module fwd_unit
  import pipeline_pkg::*;
(
  input  logic [REG_W-1:0] src_r,
  input  logic [REG_W-1:0] mem_rw,
  input  logic             mem_we,
  input  logic [REG_W-1:0] wb_rw,
  input  logic             wb_we,
  output fwd_sel_t         sel
);

  // Priority compare against the two younger-to-older producers
  always_comb begin
    sel = FWD_RF;
    if (mem_we && (mem_rw == src_r) && (mem_rw != XZR)) begin
      sel = FWD_MEM;
    end else if (wb_we && (wb_rw == src_r) && (wb_rw != XZR)) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller: load-use and flag-hazard stalls, taken-branch flushes, forwarding, perf counters.
module hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  hazard_ctrl_if.slave     hz,
  input  logic             clear_cnt,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  hz_state_t           state_q, state_d;
  logic [STALL_CW-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0]    stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0]    flush_events_q, flush_events_d;
  logic                load_use;
  logic                flag_hz;
  logic                stall;
  logic                stall_cycle;

  // Hazard detection on the ID instruction against the EX/MEM producers
  always_comb begin
    load_use = hz.ex_MemRead && hz.ex_RegWrite && (hz.ex_Rw != XZR) &&
               ((hz.id_useRa && (hz.id_Ra == hz.ex_Rw)) ||
                (hz.id_useRb && (hz.id_Rb == hz.ex_Rw)));
    flag_hz  = hz.id_isBcond && (hz.ex_setFlags || hz.mem_setFlags);
  end

  // Stall FSM next state and pipeline control; a taken branch overrides any stall
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    stall           = 1'b0;
    hz.pc_en        = 1'b1;
    hz.if_id_en     = 1'b1;
    hz.if_id_flush  = 1'b0;
    hz.id_ex_flush  = 1'b0;
    hz.ex_mem_flush = 1'b0;
    case (state_q)
      RUN: begin
        stall = load_use || flag_hz;
        // flags still one stage away in EX need one extra held cycle
        if (flag_hz && hz.ex_setFlags) begin
          state_d = STALL;
          cnt_d   = STALL_CW'(1);
        end
      end
      STALL: begin
        stall = 1'b1;
        // leave once the down-counter reaches zero
        if (cnt_q <= STALL_CW'(1)) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - STALL_CW'(1);
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
    if (stall) begin
      hz.pc_en       = 1'b0;
      hz.if_id_en    = 1'b0;
      hz.id_ex_flush = 1'b1;
    end
    if (hz.br_taken) begin
      hz.pc_en        = 1'b1;
      hz.if_id_en     = 1'b1;
      hz.if_id_flush  = 1'b1;
      hz.id_ex_flush  = 1'b1;
      hz.ex_mem_flush = 1'b1;
      state_d         = RUN;
      cnt_d           = '0;
    end
    stall_cycle = stall && !hz.br_taken;
  end

  // Saturating performance counters; clear wins over increment
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_events_d = flush_events_q;
    if (clear_cnt) begin
      stall_cycles_d = '0;
      flush_events_d = '0;
    end else begin
      if (stall_cycle && (stall_cycles_q != '1)) begin
        stall_cycles_d = stall_cycles_q + CNT_W'(1);
      end
      if (hz.br_taken && (flush_events_q != '1)) begin
        flush_events_d = flush_events_q + CNT_W'(1);
      end
    end
  end

  // State and counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= RUN;
      cnt_q          <= '0;
      stall_cycles_q <= '0;
      flush_events_q <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      stall_cycles_q <= stall_cycles_d;
      flush_events_q <= flush_events_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_events = flush_events_q;

  fwd_unit u_fwd_a (
    .src_r  (hz.ex_Ra),
    .mem_rw (hz.mem_Rw),
    .mem_we (hz.mem_RegWrite),
    .wb_rw  (hz.wb_Rw),
    .wb_we  (hz.wb_RegWrite),
    .sel    (hz.fwdA)
  );

  fwd_unit u_fwd_b (
    .src_r  (hz.ex_Rb),
    .mem_rw (hz.mem_Rw),
    .mem_we (hz.mem_RegWrite),
    .wb_rw  (hz.wb_Rw),
    .wb_we  (hz.wb_RegWrite),
    .sel    (hz.fwdB)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: stalls, branch flush, forwarding, counter saturation/clear, async reset.
module tb_hazard_ctrl;
  import pipeline_pkg::*;

  localparam int unsigned CNT_W = 4;

  logic             clk;
  logic             reset;
  logic             clear_cnt;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_events;
  int               n_checks;
  int               n_pass;

  hazard_ctrl_if hz ();

  hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .hz           (hz),
    .clear_cnt    (clear_cnt),
    .stall_cycles (stall_cycles),
    .flush_events (flush_events)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic idle();
    hz.id_Ra = '0; hz.id_Rb = '0; hz.id_useRa = 1'b0; hz.id_useRb = 1'b0;
    hz.id_isBcond = 1'b0;
    hz.ex_Rw = '0; hz.ex_RegWrite = 1'b0; hz.ex_MemRead = 1'b0; hz.ex_setFlags = 1'b0;
    hz.ex_Ra = '0; hz.ex_Rb = '0;
    hz.mem_Rw = '0; hz.mem_RegWrite = 1'b0; hz.mem_setFlags = 1'b0; hz.br_taken = 1'b0;
    hz.wb_Rw = '0; hz.wb_RegWrite = 1'b0;
    clear_cnt = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_use_x2();
    hz.ex_Rw = 5'd2; hz.ex_MemRead = 1'b1; hz.ex_RegWrite = 1'b1;
    hz.id_Ra = 5'd2; hz.id_useRa = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset    = 1'b0;
    idle();
    #2;
    check("rst_pc_en", 32'(hz.pc_en), 1);
    check("rst_id_ex_flush", 32'(hz.id_ex_flush), 0);
    check("rst_stall_cycles", 32'(stall_cycles), 0);
    check("rst_flush_events", 32'(flush_events), 0);
    #10 reset = 1'b1;
    tick();

    // load-use: exactly one held cycle
    load_use_x2();
    #1;
    check("lu_pc_en", 32'(hz.pc_en), 0);
    check("lu_if_id_en", 32'(hz.if_id_en), 0);
    check("lu_id_ex_flush", 32'(hz.id_ex_flush), 1);
    tick();
    idle();
    #1;
    check("lu_release_pc_en", 32'(hz.pc_en), 1);
    check("lu_stall_cycles", 32'(stall_cycles), 1);

    // load-use masked by use bit, and by XZR destination
    load_use_x2(); hz.id_useRa = 1'b0;
    #1;
    check("lu_unused_pc_en", 32'(hz.pc_en), 1);
    load_use_x2(); hz.ex_Rw = 5'd31; hz.id_Ra = 5'd31;
    #1;
    check("lu_xzr_pc_en", 32'(hz.pc_en), 1);
    idle();
    tick();

    // flag hazard with SUBS in EX: two stall cycles
    hz.id_isBcond = 1'b1; hz.ex_setFlags = 1'b1;
    #1;
    check("fex_c1_pc_en", 32'(hz.pc_en), 0);
    tick();
    hz.ex_setFlags = 1'b0; hz.mem_setFlags = 1'b0;
    #1;
    check("fex_c2_pc_en", 32'(hz.pc_en), 0);
    tick();
    #1;
    check("fex_done_pc_en", 32'(hz.pc_en), 1);
    check("fex_stall_cycles", 32'(stall_cycles), 3);

    // flag hazard with SUBS in MEM only: one stall cycle
    hz.mem_setFlags = 1'b1;
    #1;
    check("fmem_c1_pc_en", 32'(hz.pc_en), 0);
    tick();
    hz.mem_setFlags = 1'b0;
    #1;
    check("fmem_done_pc_en", 32'(hz.pc_en), 1);
    check("fmem_stall_cycles", 32'(stall_cycles), 4);

    // taken branch in the second cycle of a flag stall
    hz.ex_setFlags = 1'b1;
    tick();
    hz.ex_setFlags = 1'b0; hz.mem_setFlags = 1'b1; hz.br_taken = 1'b1;
    #1;
    check("br_if_id_flush", 32'(hz.if_id_flush), 1);
    check("br_id_ex_flush", 32'(hz.id_ex_flush), 1);
    check("br_ex_mem_flush", 32'(hz.ex_mem_flush), 1);
    check("br_pc_en", 32'(hz.pc_en), 1);
    check("br_if_id_en", 32'(hz.if_id_en), 1);
    tick();
    hz.br_taken = 1'b0; hz.mem_setFlags = 1'b0;
    #1;
    check("br_run_pc_en", 32'(hz.pc_en), 1);
    check("br_flush_events", 32'(flush_events), 1);
    check("br_stall_cycles", 32'(stall_cycles), 5);
    idle();

    // forwarding
    hz.mem_Rw = 5'd5; hz.wb_Rw = 5'd5; hz.mem_RegWrite = 1'b1; hz.wb_RegWrite = 1'b1;
    hz.ex_Ra = 5'd5; hz.ex_Rb = 5'd31;
    #1;
    check("fwdA_mem", 32'(hz.fwdA), 2);
    check("fwdB_xzr", 32'(hz.fwdB), 0);
    hz.mem_RegWrite = 1'b0;
    #1;
    check("fwdA_wb", 32'(hz.fwdA), 1);
    hz.mem_RegWrite = 1'b1; hz.mem_Rw = 5'd9; hz.wb_Rw = 5'd7; hz.ex_Rb = 5'd7; hz.ex_Ra = 5'd3;
    #1;
    check("fwdA_rf", 32'(hz.fwdA), 0);
    check("fwdB_wb", 32'(hz.fwdB), 1);
    hz.mem_Rw = 5'd31; hz.wb_Rw = 5'd31; hz.ex_Ra = 5'd31;
    #1;
    check("fwdA_xzr", 32'(hz.fwdA), 0);
    idle();

    // clear, saturate, clear-over-increment
    clear_cnt = 1'b1;
    tick();
    clear_cnt = 1'b0;
    check("clr_stall_cycles", 32'(stall_cycles), 0);
    check("clr_flush_events", 32'(flush_events), 0);
    load_use_x2();
    for (int i = 0; i < 15; i++) tick();
    check("sat_reach", 32'(stall_cycles), 15);
    tick();
    check("sat_hold", 32'(stall_cycles), 15);
    clear_cnt = 1'b1;
    tick();
    check("clr_over_inc", 32'(stall_cycles), 0);
    idle();

    // async reset in the middle of a STALL
    hz.id_isBcond = 1'b1; hz.ex_setFlags = 1'b1;
    tick();
    hz.id_isBcond = 1'b0; hz.ex_setFlags = 1'b0;
    #1;
    check("mid_stall_pc_en", 32'(hz.pc_en), 0);
    check("mid_stall_cnt", 32'(stall_cycles), 1);
    reset = 1'b0;
    #1;
    check("async_rst_pc_en", 32'(hz.pc_en), 1);
    check("async_rst_stall_cycles", 32'(stall_cycles), 0);
    #2 reset = 1'b1;
    tick();
    check("post_rst_pc_en", 32'(hz.pc_en), 1);
    check("post_rst_stall_cycles", 32'(stall_cycles), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
